// File: rtl/memory_sequencer_if.sv
// Shared memory-protocol types plus the sequencer's command/memory bus bundle.
// master = sequencer side; slave = control unit + memory side.
package mem_seq_pkg;
  typedef enum logic [1:0] {MEM_NONE = 2'd0, MEM_READ = 2'd1, MEM_WRITE = 2'd2} memory_op_e;
  typedef enum logic {BUS_MAR = 1'b0, BUS_PC = 1'b1} memory_bus_selector_e;
  typedef enum logic [2:0] {
    IR_NONE = 3'd0, IR_INC = 3'd1, IR_ABSOLUTE = 3'd2, IR_REL_ADD = 3'd3, IR_REL_SUB = 3'd4
  } instruction_reg_op_e;

  localparam logic [2:0] CMD_FETCH     = 3'd0;
  localparam logic [2:0] CMD_LOAD      = 3'd1;
  localparam logic [2:0] CMD_STORE     = 3'd2;
  localparam logic [2:0] CMD_JUMP_ABS  = 3'd3;
  localparam logic [2:0] CMD_JUMP_FWD  = 3'd4;
  localparam logic [2:0] CMD_JUMP_BACK = 3'd5;
endpackage

interface memory_sequencer_if;
  import mem_seq_pkg::*;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd;
  logic [7:0]           cmd_addr;
  logic                 cmd_word;
  logic [7:0]           cmd_wdata;
  logic                 done;
  logic                 err;
  logic [7:0]           instr_hi;
  logic [7:0]           instr_lo;
  logic [7:0]           load_data;
  logic [7:0]           mem_in;
  logic [7:0]           mem_out;
  memory_op_e           mem_op;
  memory_bus_selector_e mem_bus_sel;
  logic                 mem_dws;
  instruction_reg_op_e  mem_ir_op;

  modport master (
    input  cmd_valid, cmd, cmd_addr, cmd_word, cmd_wdata, mem_out,
    output cmd_ready, done, err, instr_hi, instr_lo, load_data,
           mem_in, mem_op, mem_bus_sel, mem_dws, mem_ir_op
  );
  modport slave (
    output cmd_valid, cmd, cmd_addr, cmd_word, cmd_wdata, mem_out,
    input  cmd_ready, done, err, instr_hi, instr_lo, load_data,
           mem_in, mem_op, mem_bus_sel, mem_dws, mem_ir_op
  );
endinterface

// File: rtl/memory_sequencer.sv
// Expands single-cycle control commands into multi-cycle memory sequences.
// Optional MEM_SEQ_PERF_EN adds the fetch_count performance counter.
module memory_sequencer
  import mem_seq_pkg::*;
#(
  parameter int PERF_CNT_W = 16
) (
  input  logic clock,
  input  logic reset,
  memory_sequencer_if.master bus
`ifdef MEM_SEQ_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] fetch_count
`endif
);

  typedef enum logic [3:0] {
    IDLE, F_HI, F_LO, F_INC, L_MAR, L_RD, L_CAP, S_MAR, S_WR, J_EXE, FIN
  } state_e;

  state_e     state, state_nx;
  logic [2:0] c_cmd;
  logic [7:0] c_addr, c_wdata;
  logic       c_word;
  logic [7:0] instr_hi_q, instr_lo_q, load_data_q;
  logic       err_q;
  logic       accept;

  assign accept        = (state == IDLE) && bus.cmd_valid;
  assign bus.cmd_ready = (state == IDLE);
  assign bus.done      = (state == FIN);
  assign bus.err       = err_q;
  assign bus.instr_hi  = instr_hi_q;
  assign bus.instr_lo  = instr_lo_q;
  assign bus.load_data = load_data_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      c_cmd       <= '0;
      c_addr      <= '0;
      c_word      <= 1'b0;
      c_wdata     <= '0;
      instr_hi_q  <= '0;
      instr_lo_q  <= '0;
      load_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= accept && (bus.cmd > CMD_JUMP_BACK);
      if (accept) begin
        c_cmd   <= bus.cmd;
        c_addr  <= bus.cmd_addr;
        c_word  <= bus.cmd_word;
        c_wdata <= bus.cmd_wdata;
      end
      // Each read holds READ for two cycles; data is valid in the second.
      if (state == F_LO)  instr_hi_q  <= bus.mem_out;
      if (state == F_INC) instr_lo_q  <= bus.mem_out;
      if (state == L_CAP) load_data_q <= bus.mem_out;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.cmd_valid) begin
        case (bus.cmd)
          CMD_FETCH:                              state_nx = F_HI;
          CMD_LOAD:                               state_nx = L_MAR;
          CMD_STORE:                              state_nx = S_MAR;
          CMD_JUMP_ABS, CMD_JUMP_FWD, CMD_JUMP_BACK: state_nx = J_EXE;
          default:                                state_nx = IDLE;
        endcase
      end
      F_HI:  state_nx = F_LO;
      F_LO:  state_nx = F_INC;
      F_INC: state_nx = FIN;
      L_MAR: state_nx = L_RD;
      L_RD:  state_nx = L_CAP;
      L_CAP: state_nx = FIN;
      S_MAR: state_nx = S_WR;
      S_WR:  state_nx = FIN;
      J_EXE: state_nx = FIN;
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory drive is decoded purely from state and latched command fields.
  always_comb begin
    bus.mem_op      = MEM_NONE;
    bus.mem_bus_sel = BUS_MAR;
    bus.mem_dws     = 1'b0;
    bus.mem_ir_op   = IR_NONE;
    bus.mem_in      = 8'h00;
    case (state)
      F_HI: begin
        bus.mem_op = MEM_READ; bus.mem_bus_sel = BUS_PC;
      end
      F_LO: begin
        bus.mem_op = MEM_READ; bus.mem_bus_sel = BUS_PC; bus.mem_dws = 1'b1;
      end
      F_INC: begin
        bus.mem_op = MEM_READ; bus.mem_bus_sel = BUS_PC; bus.mem_dws = 1'b1;
        bus.mem_ir_op = IR_INC;
      end
      L_MAR, S_MAR: begin
        bus.mem_ir_op = IR_ABSOLUTE; bus.mem_in = c_addr;
      end
      L_RD, L_CAP: begin
        bus.mem_op = MEM_READ; bus.mem_dws = c_word;
      end
      S_WR: begin
        bus.mem_op = MEM_WRITE; bus.mem_dws = c_word; bus.mem_in = c_wdata;
      end
      J_EXE: begin
        bus.mem_bus_sel = BUS_PC;
        bus.mem_in      = c_addr;
        case (c_cmd)
          CMD_JUMP_FWD:  bus.mem_ir_op = IR_REL_ADD;
          CMD_JUMP_BACK: bus.mem_ir_op = IR_REL_SUB;
          default:       bus.mem_ir_op = IR_ABSOLUTE;
        endcase
      end
      default: ;
    endcase
  end

`ifdef MEM_SEQ_PERF_EN
  always_ff @(posedge clock) begin
    if (reset)
      fetch_count <= '0;
    else if (state == FIN && c_cmd == CMD_FETCH)
      fetch_count <= fetch_count + 1'b1;
  end
`else
  logic unused_perf_w;
  assign unused_perf_w = |PERF_CNT_W;
`endif

endmodule

// File: tb/tb_memory_sequencer.sv
// Self-checking bench: behavioural memory model, vector table and scoreboard.
module tb_memory_sequencer;
  import mem_seq_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  memory_sequencer_if bus_if();
`ifdef MEM_SEQ_PERF_EN
  logic [15:0] fetch_count;
`endif

  memory_sequencer #(.PERF_CNT_W(16)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus_if.master)
`ifdef MEM_SEQ_PERF_EN
    ,
    .fetch_count(fetch_count)
`endif
  );

  // ---------------- memory model ----------------
  logic [7:0] mem [0:255][0:1];
  logic [7:0] pc = 8'h00, mar = 8'h00, out_reg = 8'h00, fetch_rd_pc = 8'h00;
  logic       preload = 1'b1;
  memory_op_e           op_n  = MEM_NONE;
  memory_bus_selector_e sel_n = BUS_MAR;
  logic                 dws_n = 1'b0;

  always @(negedge clock) begin
    op_n  <= bus_if.mem_op;
    sel_n <= bus_if.mem_bus_sel;
    dws_n <= bus_if.mem_dws;
    if (preload) begin
      mem[8'h00][0] <= 8'hA5; mem[8'h00][1] <= 8'h3C;
      mem[8'h10][0] <= 8'h11; mem[8'h10][1] <= 8'h00;
      mem[8'h22][0] <= 8'h5A; mem[8'h22][1] <= 8'hC3;
      mem[8'h23][0] <= 8'h77; mem[8'h23][1] <= 8'h88;
      mem[8'h24][0] <= 8'h12; mem[8'h24][1] <= 8'h34;
      mem[8'h25][0] <= 8'h56; mem[8'h25][1] <= 8'h78;
    end
    if (bus_if.mem_op == MEM_WRITE) mem[mar][bus_if.mem_dws] <= bus_if.mem_in;
    case (bus_if.mem_ir_op)
      IR_INC:      pc <= pc + 8'd1;
      IR_ABSOLUTE: if (bus_if.mem_bus_sel == BUS_PC) pc <= bus_if.mem_in; else mar <= bus_if.mem_in;
      IR_REL_ADD:  pc <= pc + bus_if.mem_in;
      IR_REL_SUB:  pc <= pc - bus_if.mem_in;
      default: ;
    endcase
  end

  always @(posedge clock) begin
    if (op_n == MEM_READ) begin
      out_reg <= mem[(sel_n == BUS_PC) ? pc : mar][dws_n];
      if (sel_n == BUS_PC && !dws_n) fetch_rd_pc <= pc;
    end
  end

  assign bus_if.mem_out = (bus_if.mem_op == MEM_READ) ? out_reg : 8'h00;

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] cmd;
    logic [7:0] addr;
    logic       word;
    logic [7:0] wdata;
    int         lat;
    logic       is_err;
    logic [7:0] hi, lo, ld, pc, rd_pc;
  } vec_t;

  vec_t sb[$];

  task automatic run_cmd(input vec_t v);
    vec_t e;
    int   n;
    logic got, bad_write, bad_act;
    @(negedge clock);
    chk("ready_before", 32'(bus_if.cmd_ready), 32'd1);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd       = v.cmd;
    bus_if.cmd_addr  = v.addr;
    bus_if.cmd_word  = v.word;
    bus_if.cmd_wdata = v.wdata;
    sb.push_back(v);
    @(posedge clock);
    #1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd       = 3'($urandom);
    bus_if.cmd_addr  = 8'($urandom);
    bus_if.cmd_word  = 1'($urandom);
    bus_if.cmd_wdata = 8'($urandom);
    n = 0; got = 1'b0; bad_write = 1'b0; bad_act = 1'b0;
    while (!got && n < 20) begin
      @(negedge clock);
      n++;
      if (v.cmd == CMD_LOAD && bus_if.mem_op == MEM_WRITE) bad_write = 1'b1;
      if (v.is_err && bus_if.mem_op != MEM_NONE) bad_act = 1'b1;
      if (bus_if.done || bus_if.err) got = 1'b1;
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL timeout: cmd %0d got no done/err within 20 cycles", v.cmd);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    chk("latency", 32'(n), 32'(e.lat));
    chk("done_err", {30'd0, bus_if.done, bus_if.err}, {30'd0, !e.is_err, e.is_err});
    chk("no_write_in_load", 32'(bad_write), 32'd0);
    chk("no_mem_on_err", 32'(bad_act), 32'd0);
    @(negedge clock);
    chk("pulse_end", {30'd0, bus_if.done, bus_if.err}, 32'd0);
    chk("ready_after", 32'(bus_if.cmd_ready), 32'd1);
    chk("instr_hi", 32'(bus_if.instr_hi), 32'(e.hi));
    chk("instr_lo", 32'(bus_if.instr_lo), 32'(e.lo));
    chk("load_data", 32'(bus_if.load_data), 32'(e.ld));
    chk("pc", 32'(pc), 32'(e.pc));
    if (e.cmd == CMD_FETCH) chk("fetch_rd_pc", 32'(fetch_rd_pc), 32'(e.rd_pc));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_op"},  32'(bus_if.mem_op), 32'(MEM_NONE));
    chk({tag, "_ir"},  32'(bus_if.mem_ir_op), 32'(IR_NONE));
    chk({tag, "_bus"}, {22'd0, bus_if.mem_bus_sel, bus_if.mem_dws, bus_if.mem_in},
        {22'd0, BUS_MAR, 1'b0, 8'h00});
    chk({tag, "_ready"}, 32'(bus_if.cmd_ready), 32'd1);
    chk({tag, "_pulses"}, {30'd0, bus_if.done, bus_if.err}, 32'd0);
  endtask

  vec_t tbl[10];
  vec_t v;

  initial begin
    //         cmd           addr   w  wdata  lat err hi     lo     ld     pc     rd_pc
    tbl[0] = '{CMD_FETCH,     8'h00, 0, 8'h00, 4, 0, 8'hA5, 8'h3C, 8'h00, 8'h01, 8'h00};
    tbl[1] = '{CMD_STORE,     8'h10, 1, 8'h7E, 3, 0, 8'hA5, 8'h3C, 8'h00, 8'h01, 8'h00};
    tbl[2] = '{CMD_LOAD,      8'h10, 1, 8'h00, 4, 0, 8'hA5, 8'h3C, 8'h7E, 8'h01, 8'h00};
    tbl[3] = '{CMD_LOAD,      8'h10, 0, 8'h00, 4, 0, 8'hA5, 8'h3C, 8'h11, 8'h01, 8'h00};
    tbl[4] = '{CMD_JUMP_ABS,  8'h20, 0, 8'h00, 2, 0, 8'hA5, 8'h3C, 8'h11, 8'h20, 8'h00};
    tbl[5] = '{CMD_JUMP_FWD,  8'h05, 0, 8'h00, 2, 0, 8'hA5, 8'h3C, 8'h11, 8'h25, 8'h00};
    tbl[6] = '{CMD_JUMP_BACK, 8'h03, 0, 8'h00, 2, 0, 8'hA5, 8'h3C, 8'h11, 8'h22, 8'h00};
    tbl[7] = '{CMD_FETCH,     8'h00, 0, 8'h00, 4, 0, 8'h5A, 8'hC3, 8'h11, 8'h23, 8'h22};
    tbl[8] = '{3'd6,          8'h44, 1, 8'h99, 1, 1, 8'h5A, 8'hC3, 8'h11, 8'h23, 8'h00};
    tbl[9] = '{3'd7,          8'h55, 0, 8'h66, 1, 1, 8'h5A, 8'hC3, 8'h11, 8'h23, 8'h00};

    bus_if.cmd_valid = 1'b0;
    bus_if.cmd       = 3'd0;
    bus_if.cmd_addr  = 8'h00;
    bus_if.cmd_word  = 1'b0;
    bus_if.cmd_wdata = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    preload = 1'b0;
    chk_idle("rst");
    chk("rst_regs", {8'd0, bus_if.instr_hi, bus_if.instr_lo, bus_if.load_data}, 32'd0);
`ifdef MEM_SEQ_PERF_EN
    chk("rst_fetch_count", 32'(fetch_count), 32'd0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_cmd(tbl[i]);

    // Reset in the middle of a fetch (during F_LO) abandons it.
    @(negedge clock);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd       = CMD_FETCH;
    @(posedge clock);
    #1 bus_if.cmd_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("mid_fetch_op", 32'(bus_if.mem_op), 32'(MEM_READ));
    reset = 1'b1;
    @(negedge clock);
    chk_idle("mid_rst");
    chk("mid_rst_regs", {8'd0, bus_if.instr_hi, bus_if.instr_lo, bus_if.load_data}, 32'd0);
    reset = 1'b0;

    v = '{CMD_FETCH, 8'h00, 0, 8'h00, 4, 0, 8'h77, 8'h88, 8'h00, 8'h24, 8'h23};
    run_cmd(v);
    v = '{CMD_FETCH, 8'h00, 0, 8'h00, 4, 0, 8'h12, 8'h34, 8'h00, 8'h25, 8'h24};
    run_cmd(v);
    v = '{CMD_FETCH, 8'h00, 0, 8'h00, 4, 0, 8'h56, 8'h78, 8'h00, 8'h26, 8'h25};
    run_cmd(v);
    v = '{CMD_LOAD,  8'h10, 1, 8'h00, 4, 0, 8'h56, 8'h78, 8'h7E, 8'h26, 8'h00};
    run_cmd(v);
`ifdef MEM_SEQ_PERF_EN
    chk("fetch_count", 32'(fetch_count), 32'd3);
    reset = 1'b1;
    @(negedge clock);
    chk("fetch_count_rst", 32'(fetch_count), 32'd0);
    reset = 1'b0;
`endif
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
